// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller: segment patterns
// and the scan-state encoding.
package seg7_pkg;

  // Segment order is {g,f,e,d,c,b,a}; 1 = lit.
  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// BCD to 7-segment decoder; values above 9 render as a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    // NOTE: o_seg gets a default before any branch so no path leaves it unassigned (no latch).
    o_seg = SEG_DASH;
    if (i_bcd <= 4'd9) begin
      o_seg = SEG_LUT[i_bcd];
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a double-buffered load port.
// Outputs are registered from next-cycle state, so they line up with the scan position.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_bcd,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  scan_state_e                 r_state;
  logic [CNT_W-1:0]            r_cnt;
  logic [IDX_W-1:0]            r_idx;
  logic [4*NUM_DIGITS-1:0]     r_act_bcd;
  logic [NUM_DIGITS-1:0]       r_act_dp;
  logic [4*NUM_DIGITS-1:0]     r_pend_bcd;
  logic [NUM_DIGITS-1:0]       r_pend_dp;
  logic                        r_pend;
  logic                        r_ready;
  logic [6:0]                  r_seg;
  logic                        r_dp;
  logic [NUM_DIGITS-1:0]       r_an;
  logic                        r_frame_done;

  scan_state_e                 w_state_nxt;
  logic                        w_wrap;
  logic [CNT_W-1:0]            w_cnt_nxt;
  logic [IDX_W-1:0]            w_idx_nxt;
  logic                        w_fd_nxt;
  logic                        w_xfer;
  logic                        w_commit;
  logic                        w_pend_nxt;
  logic                        w_ready_nxt;
  logic [4*NUM_DIGITS-1:0]     w_act_bcd_nxt;
  logic [NUM_DIGITS-1:0]       w_act_dp_nxt;
  logic [NUM_DIGITS-1:0]       w_zero_from;
  logic                        w_zero_acc;
  logic [3:0]                  w_digit;
  logic                        w_digit_dp;
  logic                        w_suppress;
  logic [6:0]                  w_dec_seg;
  logic [6:0]                  w_seg_nxt;
  logic                        w_dp_nxt;
  logic [NUM_DIGITS-1:0]       w_an_nxt;

  always_comb begin
    w_wrap    = (r_cnt == CNT_LAST);
    w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
    w_idx_nxt = r_idx;
    if (w_wrap) begin
      w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
    w_fd_nxt = (w_idx_nxt == IDX_LAST) && (w_cnt_nxt == CNT_LAST);
  end

  // Commit happens only on the frame_done cycle, so a new word never tears a frame.
  always_comb begin
    w_xfer        = load_valid && r_ready;
    w_commit      = r_frame_done && r_pend;
    w_pend_nxt    = r_pend;
    if (w_commit) begin
      w_pend_nxt = 1'b0;
    end else if (w_xfer) begin
      w_pend_nxt = 1'b1;
    end
    w_ready_nxt   = !w_pend_nxt && !w_fd_nxt;
    w_act_bcd_nxt = w_commit ? r_pend_bcd : r_act_bcd;
    w_act_dp_nxt  = w_commit ? r_pend_dp  : r_act_dp;
  end

  always_comb begin
    w_zero_acc  = 1'b1;
    w_zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_acc     = w_zero_acc && (w_act_bcd_nxt[i*4 +: 4] == 4'd0);
      w_zero_from[i] = w_zero_acc;
    end
    w_digit    = '0;
    w_digit_dp = 1'b0;
    w_suppress = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_nxt == IDX_W'(i)) begin
        w_digit    = w_act_bcd_nxt[i*4 +: 4];
        w_digit_dp = w_act_dp_nxt[i];
        w_suppress = blank_lz && (i > 0) && w_zero_from[i];
      end
    end
  end

  seg7_decode u_decode (
    .i_bcd (w_digit),
    .o_seg (w_dec_seg)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BLANK: if (w_cnt_nxt == CNT_SHOW) w_state_nxt = S_SHOW;
      S_SHOW:  if (w_wrap)                w_state_nxt = S_BLANK;
      default:                            w_state_nxt = S_BLANK;
    endcase

    w_an_nxt  = '0;
    w_seg_nxt = SEG_OFF;
    w_dp_nxt  = 1'b0;
    if (w_state_nxt == S_SHOW) begin
      w_an_nxt  = NUM_DIGITS'(1) << w_idx_nxt;
      w_seg_nxt = w_suppress ? SEG_OFF : w_dec_seg;
      w_dp_nxt  = w_digit_dp;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // NOTE: both buffers are plain registers and are cleared, so the display shows zeros after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_bcd  <= '0;
      r_act_dp   <= '0;
      r_pend_bcd <= '0;
      r_pend_dp  <= '0;
      r_pend     <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      if (w_xfer) begin
        r_pend_bcd <= load_bcd;
        r_pend_dp  <= load_dp;
      end
      r_act_bcd <= w_act_bcd_nxt;
      r_act_dp  <= w_act_dp_nxt;
      r_pend    <= w_pend_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b0;
      r_an         <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_an         <= w_an_nxt;
      r_frame_done <= w_fd_nxt;
    end
  end

  assign load_ready = r_ready;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: a cycle-indexed behavioural model
// checked every cycle, plus literal expectations at hand-computed cycles.
module tb_seg7_scan_ctrl;

  localparam int N = 4;
  localparam int P = 8;
  localparam int B = 2;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [4*N-1:0] load_bcd = '0;
  logic [N-1:0]  load_dp = '0;
  logic          blank_lz = 1'b0;
  logic [6:0]    seg;
  logic          dp;
  logic [N-1:0]  an;
  logic          frame_done;

  int errors = 0;
  int checks = 0;

  int          t;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_act_dp, m_pend_dp;
  bit          m_has_pend;
  bit          lz_last;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (N),
    .PRESCALE     (P),
    .BLANK_CYCLES (B)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_bcd   (load_bcd),
    .load_dp    (load_dp),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %0h, expected %0h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t          = 0;
    m_act      = '0;
    m_pend     = '0;
    m_act_dp   = '0;
    m_pend_dp  = '0;
    m_has_pend = 1'b0;
    lz_last    = 1'b0;
  endtask

  // Hold reset for two cycles, check reset values, release at a falling edge.
  task automatic do_reset();
    rst_n      = 1'b0;
    load_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_seg", seg, 0);
    check("rst_an", an, 0);
    check("rst_dp", dp, 0);
    check("rst_fd", frame_done, 0);
    check("rst_ready", load_ready, 1);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Compare the DUT against the model for cycle t, then apply this cycle's inputs across one edge.
  task automatic cycle(input bit v, input logic [15:0] b, input logic [3:0] d, input bit lz);
    int         cnt, idx;
    bit         fd, rdy, blank, suppress;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    load_valid = v;
    load_bcd   = b;
    load_dp    = d;
    blank_lz   = lz;
    cnt      = t % P;
    idx      = (t / P) % N;
    fd       = (idx == N - 1) && (cnt == P - 1);
    rdy      = !m_has_pend && !fd;
    blank    = (cnt < B);
    suppress = lz_last && (idx > 0) && ((m_act >> (4 * idx)) == 16'd0);
    e_an     = blank ? 4'b0000 : 4'(1 << idx);
    e_seg    = (blank || suppress) ? 7'd0 : SEG_TAB[m_act[4*idx +: 4]];
    e_dp     = blank ? 1'b0 : m_act_dp[idx];
    check("an", an, e_an);
    check("seg", seg, e_seg);
    check("dp", dp, e_dp);
    check("frame_done", frame_done, fd);
    check("load_ready", load_ready, rdy);
    if (fd && m_has_pend) begin
      m_act      = m_pend;
      m_act_dp   = m_pend_dp;
      m_has_pend = 1'b0;
    end
    if (v && rdy) begin
      m_pend     = b;
      m_pend_dp  = d;
      m_has_pend = 1'b1;
    end
    lz_last = lz;
    t++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    @(negedge clk);

    // Scan timing and first load.
    do_reset();
    while (t < 64) begin
      if (t == 0)  check("c0_an", an, 4'b0000);
      if (t == 1)  check("c1_an", an, 4'b0000);
      if (t == 2)  check("c2_an", an, 4'b0001);
      if (t == 7)  check("c7_an", an, 4'b0001);
      if (t == 8)  check("c8_an", an, 4'b0000);
      if (t == 10) check("c10_an", an, 4'b0010);
      if (t == 4)  check("c4_ready", load_ready, 0);
      if (t == 26) check("c26_seg_zero", seg, 7'b0111111);
      if (t == 30) check("c30_fd", frame_done, 0);
      if (t == 31) check("c31_fd", frame_done, 1);
      if (t == 32) check("c32_ready", load_ready, 1);
      if (t == 34) check("c34_seg", seg, 7'b1100110);
      if (t == 34) check("c34_dp", dp, 1);
      if (t == 58) check("c58_an", an, 4'b1000);
      if (t == 58) check("c58_seg", seg, 7'b0000110);
      cycle(t == 3, 16'h1234, 4'b0001, 1'b0);
    end

    // Leading-zero suppression, then switched off.
    do_reset();
    while (t < 100) begin
      if (t == 34) check("lz_d0", seg, 7'b0111111);
      if (t == 42) check("lz_d1", seg, 7'b0000111);
      if (t == 50) check("lz_d2_seg", seg, 7'b0000000);
      if (t == 50) check("lz_d2_an", an, 4'b0100);
      if (t == 58) check("lz_d3_seg", seg, 7'b0000000);
      if (t == 58) check("lz_d3_an", an, 4'b1000);
      if (t == 90) check("nolz_d3", seg, 7'b0111111);
      cycle(t == 0, 16'h0070, 4'b0000, t < 64);
    end

    // Back-to-back loads with valid held.
    do_reset();
    while (t < 100) begin
      if (t == 1)  check("b2b_ready1", load_ready, 0);
      if (t == 32) check("b2b_ready32", load_ready, 1);
      if (t == 33) check("b2b_ready33", load_ready, 0);
      if (t == 34) check("b2b_first", seg, 7'b0000110);
      if (t == 63) check("b2b_fd63", frame_done, 1);
      if (t == 66) check("b2b_second", seg, 7'b1011011);
      cycle(t <= 32, (t == 0) ? 16'h1111 : 16'h2222, 4'b0000, 1'b0);
    end

    // Invalid BCD digits.
    do_reset();
    while (t < 70) begin
      if (t == 34) check("inv_d0", seg, 7'b1000000);
      if (t == 42) check("inv_d1", seg, 7'b1000000);
      if (t == 50) check("inv_d2_lz", seg, 7'b0000000);
      if (t == 58) check("inv_d3_nolz", seg, 7'b0111111);
      cycle(t == 0, 16'h00AF, 4'b0000, t < 54);
    end

    // Reset during digit2 SHOW with a load pending.
    do_reset();
    while (t < 84) begin
      cycle((t == 0) || (t == 65), (t == 0) ? 16'h5678 : 16'h9999, 4'b0100, 1'b0);
    end
    check("pre_rst_an", an, 4'b0100);
    check("pre_rst_seg", seg, 7'b1111101);
    check("pre_rst_dp", dp, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_seg", seg, 0);
    check("async_an", an, 0);
    check("async_dp", dp, 0);
    check("async_ready", load_ready, 1);
    @(negedge clk);
    do_reset();
    while (t < 70) begin
      if (t == 34) check("post_rst_d0", seg, 7'b0111111);
      if (t == 66) check("post_rst_d0_f2", seg, 7'b0111111);
      cycle(1'b0, 16'h0000, 4'b0000, 1'b0);
    end

    // Randomized loads, digit values and suppression toggling.
    do_reset();
    begin
      bit lz = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 49) == 0) lz = !lz;
        cycle($urandom_range(0, 3) == 0, 16'($urandom),
              4'($urandom), lz);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
